// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin sharing of one external combinational multiplier with a registered response channel
module booth_mult_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int W        = 32,
  parameter int P_W      = 65,
  parameter int MULT_LAT = 2,
  parameter int ID_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic [W-1:0]         mult_a,
  output logic [W-1:0]         mult_b,
  input  logic [P_W-1:0]       mult_p,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [P_W-1:0]       resp_product,
  output logic                 busy
);
  localparam int CW = $clog2(MULT_LAT + 1);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant;
  logic            found;
  logic [CW-1:0]   lat_cnt;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        grant = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end
  assign req_ready = (rst && state == IDLE && found) ? NUM_REQ'(1) << grant : '0;
  assign busy      = state != IDLE;
  assign mult_a    = op_a;
  assign mult_b    = op_b;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      lat_cnt      <= '0;
      op_a         <= '0;
      op_b         <= '0;
      resp_id      <= '0;
      resp_product <= '0;
      resp_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          op_a    <= req_a[grant*W +: W];
          op_b    <= req_b[grant*W +: W];
          resp_id <= grant;
          rr_ptr  <= ID_W'((int'(grant) + 1) % NUM_REQ);
          lat_cnt <= CW'(MULT_LAT - 1);
          state   <= CALC;
        end
        CALC: if (lat_cnt != '0) lat_cnt <= lat_cnt - CW'(1);
        else begin
          resp_product <= mult_p;
          resp_valid   <= 1'b1;
          state        <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb_booth_mult_arbiter: scoreboard bench with an external multiplier model and a second NUM_REQ=1, MULT_LAT=1 instance
module tb_booth_mult_arbiter;
  typedef struct packed {logic [1:0] id; logic [64:0] p;} exp_t;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;
  logic [31:0]  mult_a, mult_b;
  logic [64:0]  mult_p;
  logic         resp_valid;
  logic         resp_ready = 1'b1;
  logic [1:0]   resp_id;
  logic [64:0]  resp_product;
  logic         busy;
  logic         v2 = 1'b0;
  logic         rdy2;
  logic [31:0]  a2 = '0, b2 = '0, ma2, mb2;
  logic [64:0]  mp2, p2;
  logic         rv2;
  logic         rr2 = 1'b1;
  logic         id2;
  logic         busy2;
  int           tests = 0;
  int           fails = 0;
  exp_t         exp_q[$];
  logic [31:0]  pa[4][8];
  logic [31:0]  pb[4][8];
  int           pn[4] = '{0, 0, 0, 0};
  int           prd[4] = '{0, 0, 0, 0};
  int           cyc = 0;
  int           grant_cyc = 0;
  logic         prev_valid = 1'b0;
  logic         hold_chk = 1'b0;
  logic [1:0]   hold_id;
  logic [64:0]  hold_p;

  always #5 clk = ~clk;
  assign mult_p = {{33{mult_a[31]}}, mult_a} * {{33{mult_b[31]}}, mult_b};
  assign mp2    = {{33{ma2[31]}}, ma2} * {{33{mb2[31]}}, mb2};

  booth_mult_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_product(resp_product), .busy(busy)
  );

  booth_mult_arbiter #(.NUM_REQ(1), .MULT_LAT(1), .ID_W(1)) dut2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2),
    .req_a(a2), .req_b(b2), .mult_a(ma2), .mult_b(mb2), .mult_p(mp2),
    .resp_valid(rv2), .resp_ready(rr2), .resp_id(id2),
    .resp_product(p2), .busy(busy2)
  );

  task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic load(input int i, input logic [31:0] a, input logic [31:0] b);
    pa[i][pn[i] % 8] = a;
    pb[i][pn[i] % 8] = b;
    pn[i]++;
  endtask

  task automatic expect_resp(input logic [1:0] id, input logic [64:0] p);
    exp_q.push_back('{id: id, p: p});
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && prd == pn && !busy) return;
    end
    fails++;
    tests++;
    $display("FAIL drain: timeout with %0d responses outstanding", exp_q.size());
  endtask

  task automatic run2(input logic [31:0] a, input logic [31:0] b, input logic [64:0] exp);
    @(posedge clk); #1;
    v2 = 1'b1; a2 = a; b2 = b;
    @(negedge clk);
    check("lat1 ready", 65'(rdy2), 65'd1);
    @(posedge clk); #1;
    v2 = 1'b0;
    @(negedge clk);
    check("lat1 valid early", 65'(rv2), 65'd0);
    @(negedge clk);
    check("lat1 valid", 65'(rv2), 65'd1);
    check("lat1 product", p2, exp);
    check("lat1 id", 65'(id2), 65'd0);
  endtask

  // per-requester driver: holds each pending request until its handshake is seen
  initial begin
    logic [3:0] hs;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (hs[i]) prd[i]++;
        req_valid[i] = prd[i] < pn[i];
        req_a[i*32 +: 32] = req_valid[i] ? pa[i][prd[i] % 8] : '0;
        req_b[i*32 +: 32] = req_valid[i] ? pb[i][prd[i] % 8] : '0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      prev_valid = 1'b0;
      hold_chk   = 1'b0;
    end else begin
      if (req_ready != '0) begin
        grant_cyc = cyc;
        if (!$onehot(req_ready) || (req_ready & ~req_valid) != '0 || busy) begin
          tests++;
          fails++;
          $display("FAIL grant: req_ready %b req_valid %b busy %b", req_ready, req_valid, busy);
        end
      end
      if (resp_valid && !prev_valid) check("latency", 65'(cyc - grant_cyc), 65'd3);
      if (hold_chk) begin
        check("hold valid", 65'(resp_valid), 65'd1);
        check("hold id", 65'(resp_id), 65'(hold_id));
        check("hold product", resp_product, hold_p);
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected response: id %0d product %h", resp_id, resp_product);
        end else begin
          e = exp_q.pop_front();
          check("resp id", 65'(resp_id), 65'(e.id));
          check("resp product", resp_product, e.p);
        end
      end
      hold_chk   = resp_valid && !resp_ready;
      hold_id    = resp_id;
      hold_p     = resp_product;
      prev_valid = resp_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset valid", 65'(resp_valid), 65'd0);
    check("reset busy", 65'(busy), 65'd0);
    check("reset id", 65'(resp_id), 65'd0);
    check("reset product", resp_product, 65'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    expect_resp(0, 65'd600);
    load(0, 32'd30, 32'd20);
    drain();
    expect_resp(2, 65'h1_FFFF_FFFF_FFFF_FFCE);
    expect_resp(2, 65'd600);
    load(2, 32'd10, -32'sd5);
    load(2, -32'sd30, -32'sd20);
    drain();
    expect_resp(3, 65'h0_4000_0000_0000_0000);
    load(3, 32'h8000_0000, 32'h8000_0000);
    drain();
    expect_resp(0, 65'd875);
    expect_resp(1, 65'd35);
    expect_resp(2, 65'd0);
    expect_resp(3, 65'd180);
    expect_resp(0, 65'h1_FFFF_FFFF_FFFF_FFF9);
    load(0, 32'd35, 32'd25);
    load(1, 32'd35, 32'd1);
    load(2, 32'd30, 32'd0);
    load(3, 32'd90, 32'd2);
    load(0, 32'd7, -32'sd1);
    drain();
    resp_ready = 1'b0;
    expect_resp(1, 65'h1_FFFF_FFFF_FFFF_FF70);
    expect_resp(2, 65'd25);
    load(1, 32'd12, -32'sd12);
    load(2, 32'd5, 32'd5);
    for (int n = 0; n < 50 && !resp_valid; n++) @(negedge clk);
    check("bp valid rise", 65'(resp_valid), 65'd1);
    for (int n = 0; n < 5; n++) begin
      if (n > 0) @(negedge clk);
      check("bp req_ready", 65'(req_ready), 65'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp idle busy", 65'(busy), 65'd0);
    check("bp next grant", 65'(req_ready), 65'b0100);
    drain();
    load(2, 32'd3, -32'sd20);
    for (int n = 0; n < 50 && !req_ready[2]; n++) @(negedge clk);
    check("abort grant", 65'(req_ready), 65'b0100);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort valid", 65'(resp_valid), 65'd0);
    check("abort busy", 65'(busy), 65'd0);
    check("abort id", 65'(resp_id), 65'd0);
    check("abort product", resp_product, 65'd0);
    check("abort mult_a", 65'(mult_a), 65'd0);
    check("abort ready", 65'(req_ready), 65'd0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("abort no resp", 65'(resp_valid), 65'd0);
    end
    expect_resp(1, 65'd42);
    expect_resp(3, 65'd1000000);
    load(1, 32'd6, 32'd7);
    load(3, 32'd1000, 32'd1000);
    drain();
    run2(32'd3, -32'sd20, 65'h1_FFFF_FFFF_FFFF_FFC4);
    run2(32'h7FFF_FFFF, 32'h7FFF_FFFF, 65'h0_3FFF_FFFF_0000_0001);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
- Shares one combinational 32x32 radix-4 Booth multiplier (65-bit signed product) among NUM_REQ requesters.
- Per-requester valid/ready handshake on the request side; single response channel with valid/ready and requester ID.
- Round-robin arbitration, registered operands, MULT_LAT-cycle settle window, registered product.
- Sits between the execute-stage requesters and the shared multiplier instance, which connects to the mult_* ports.

Parameters:
NUM_REQ, 4, number of requesters (>=1)
W, 32, operand width
P_W, 65, product width (2*W+1)
MULT_LAT, 2, cycles allowed for the multiplier combinational path to settle (>=1)
ID_W, 2, requester ID width (clog2(NUM_REQ), minimum 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_a  in  NUM_REQ*W  packed multiplicands; requester i uses bits [i*W +: W]
req_b  in  NUM_REQ*W  packed multipliers; same packing as req_a
mult_a  out  W  operand A to the shared multiplier
mult_b  out  W  operand B to the shared multiplier
mult_p  in  P_W  product from the shared multiplier
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_id  out  ID_W  index of the requester that owns the result
resp_product  out  P_W  registered signed product
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rr_ptr=0, lat_cnt=0, op_a=op_b=0, resp_id=0, resp_product=0, resp_valid=0, req_ready=0, busy=0. Asserting reset in any state aborts the operation in progress; no response is produced and nothing is retained.
- mult_a/mult_b are driven directly from op_a/op_b (registered); they never change combinationally with the req_* inputs.
- FSM: IDLE -> CALC -> RESP -> IDLE.
- IDLE:
  - grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_REQ.
  - req_ready[grant]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - At the clock edge: op_a/op_b <= req_a/req_b slice of grant; resp_id <= grant; rr_ptr <= (grant+1) mod NUM_REQ; lat_cnt <= MULT_LAT-1; state <= CALC.
  - With no req_valid bits set, the state, rr_ptr and all outputs hold.
- CALC:
  - req_ready = 0.
  - While lat_cnt != 0, decrement lat_cnt.
  - At lat_cnt == 0: resp_product <= mult_p; resp_valid <= 1; state <= RESP.
- RESP:
  - resp_valid, resp_id and resp_product hold stable until resp_ready=1.
  - On resp_valid & resp_ready: resp_valid <= 0; state <= IDLE.
  - No request is accepted in RESP.
  - resp_product keeps its last value after the handshake completes.
- Latency: a request granted in cycle T drives resp_valid=1 from cycle T+MULT_LAT+1. Minimum spacing between grants is MULT_LAT+2 cycles when resp_ready is held high.
- Arithmetic: the arbiter never interprets operands or product. The product is two's complement P_W bits, passed through unchanged from mult_p.
- Boundary conditions:
  - A requester may drop req_valid before it is granted; this has no side effects.
  - A requester must hold req_a/req_b stable while req_valid=1 and req_ready=0.
  - resp_ready asserted while resp_valid=0 is ignored.
  - Simultaneous requests: exactly one grant per IDLE cycle. Round-robin guarantees every continuously valid requester is granted within NUM_REQ transactions.
  - NUM_REQ=1: grant is always 0 and rr_ptr stays 0.
  - MULT_LAT=1: CALC lasts exactly one cycle.

Test Plan:
- Single request, requester 0: a=30, b=20, resp_ready=1 -> req_ready[0] high for 1 cycle; resp_valid high 3 cycles later (MULT_LAT=2); resp_product=600; resp_id=0.
- Negative operand, requester 2: a=10, b=-5 -> resp_product=0x1_FFFF_FFFF_FFFF_FFCE (-50); resp_id=2. Then a=-30, b=-20 -> resp_product=600.
- All four requesters valid continuously with distinct operands (35*25, 35*1, 30*0, 90*2) -> grant order 0,1,2,3; products 875, 35, 0, 180; a fifth transaction from requester 0 is granted next.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid rises -> resp_valid, resp_id and resp_product stable; all req_ready=0 throughout; IDLE re-entered the cycle after resp_ready=1.
- Reset mid-CALC: assert rst=0 one cycle after a grant of a=3, b=-20 -> all outputs zero immediately; no resp_valid after release; the next request from requester 1 is handled normally with rr_ptr starting at 0.
- MULT_LAT=1 build: 3*-20 -> resp_valid 2 cycles after grant; resp_product=-60 sign-extended to 65 bits.
